// File: rtl/concat_requant_if.sv
// Handshake and parameter-load bundle between the concat zero-point adder,
// the requantizer and the feature-buffer writer.
`timescale 1ns/1ps
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif

interface concat_requant_if #(
    parameter int RE_CHANNEL_IN_NUM = 16,
    parameter int DATA_W            = 32,
    parameter int COEF_W            = 32
);
    localparam int LANES = `PICTURE_NUM * RE_CHANNEL_IN_NUM;

    logic                     param_load;
    logic signed [COEF_W-1:0] scale_in;
    logic [5:0]               shift_in;
    logic [7:0]               zp_out_in;
    logic [LANES*DATA_W-1:0]  data_in;
    logic                     data_in_valid;
    logic                     data_in_ready;
    logic [LANES*8-1:0]       data_out;
    logic                     data_out_valid;
    logic                     data_out_ready;
    logic                     busy;
    logic                     param_err;

    // Requantizer side
    modport slave (
        input  param_load, scale_in, shift_in, zp_out_in,
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, busy, param_err
    );

    // Producer / consumer side
    modport master (
        output param_load, scale_in, shift_in, zp_out_in,
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, busy, param_err
    );
endinterface

// File: rtl/concat_requant.sv
// Per-lane requantizer: x*scale, rounding arithmetic right shift (half up),
// add output zero point, clamp to uint8. Three-stage valid/ready pipeline that
// advances as a whole; parameters may only be reloaded while the pipe is empty.
`timescale 1ns/1ps
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif

module concat_requant #(
    parameter int RE_CHANNEL_IN_NUM = 16,
    parameter int DATA_W            = 32,
    parameter int COEF_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    concat_requant_if.slave  bus
);
    localparam int LANES  = `PICTURE_NUM * RE_CHANNEL_IN_NUM;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] scale_q, scale_d;
    logic [5:0]               shift_q, shift_d;
    logic [7:0]               zp_q, zp_d;
    logic                     param_err_q, param_err_d;

    logic                     vld_p1_q, vld_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic                     vld_p3_q, vld_p3_d;
    logic signed [PROD_W-1:0] prod_p1_q [LANES];
    logic signed [PROD_W-1:0] prod_p1_d [LANES];
    logic signed [PROD_W-1:0] rnd_p2_q  [LANES];
    logic signed [PROD_W-1:0] rnd_p2_d  [LANES];
    logic [LANES*8-1:0]       res_p3_q, res_p3_d;

    logic adv;
    logic load_acc;
    logic accept;

    // Full-width signed product; both operands sign-extended so no bits are lost.
    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_W-1:0] x,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] ce;
        xe = {{COEF_W{x[DATA_W-1]}}, x};
        ce = {{DATA_W{c[COEF_W-1]}}, c};
        return xe * ce;
    endfunction

    // Round-half-up arithmetic shift. One guard bit keeps p + 2^(sh-1) from
    // wrapping when p is near +2^62 (e.g. -2^31 * -2^31).
    function automatic logic signed [PROD_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p,
        input logic [5:0]               sh
    );
        logic signed [SUM_W-1:0] t;
        if (sh == 6'd0) return p;
        t = {p[PROD_W-1], p} + (SUM_W'(1) << (sh - 6'd1));
        t = t >>> sh;
        return PROD_W'(t);
    endfunction

    // Clamp a signed sum into 0..255.
    function automatic logic [7:0] sat_u8(input logic signed [SUM_W-1:0] y);
        if (y[SUM_W-1]) return 8'd0;
        if (|y[SUM_W-2:8]) return 8'hFF;
        return y[7:0];
    endfunction

    // The parameter load steals the input slot for one cycle so a beat offered
    // alongside it is computed with the new parameters on the next cycle.
    assign adv                = !vld_p3_q || bus.data_out_ready;
    assign load_acc           = bus.param_load && (state_q == IDLE);
    assign bus.data_in_ready  = adv && !load_acc;
    assign accept             = bus.data_in_valid && bus.data_in_ready;
    assign bus.data_out       = res_p3_q;
    assign bus.data_out_valid = vld_p3_q;
    assign bus.busy           = (state_q == RUN);
    assign bus.param_err      = param_err_q;

    // Pipeline next-state: every stage shifts together on adv, bubbles included.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        vld_p2_d  = vld_p2_q;
        vld_p3_d  = vld_p3_q;
        prod_p1_d = prod_p1_q;
        rnd_p2_d  = rnd_p2_q;
        res_p3_d  = res_p3_q;
        if (adv) begin
            vld_p1_d = accept;
            vld_p2_d = vld_p1_q;
            vld_p3_d = vld_p2_q;
            for (int l = 0; l < LANES; l++) begin
                prod_p1_d[l]       = mul_full(bus.data_in[l*DATA_W +: DATA_W], scale_q);
                rnd_p2_d[l]        = round_shift(prod_p1_q[l], shift_q);
                res_p3_d[l*8 +: 8] = sat_u8({rnd_p2_q[l][PROD_W-1], rnd_p2_q[l]}
                                            + {{(SUM_W-8){1'b0}}, zp_q});
            end
        end
    end

    // Parameter load and sticky error for loads attempted mid-stream.
    always_comb begin
        scale_d     = scale_q;
        shift_d     = shift_q;
        zp_d        = zp_q;
        param_err_d = param_err_q || (bus.param_load && (state_q == RUN));
        if (load_acc) begin
            scale_d = bus.scale_in;
            shift_d = bus.shift_in;
            zp_d    = bus.zp_out_in;
        end
    end

    // Control FSM: RUN while any stage will hold a valid beat after this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (!(vld_p1_d || vld_p2_d || vld_p3_d)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control, parameter and output-stage registers (these carry reset values).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scale_q     <= COEF_W'(1);
            shift_q     <= 6'd0;
            zp_q        <= 8'd0;
            param_err_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            res_p3_q    <= '0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            shift_q     <= shift_d;
            zp_q        <= zp_d;
            param_err_q <= param_err_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            res_p3_q    <= res_p3_d;
        end
    end

    // Internal datapath stages; qualified by their valid bits, so no reset.
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
        rnd_p2_q  <= rnd_p2_d;
    end
endmodule

// File: tb/tb_concat_requant.sv
// Scoreboard bench for concat_requant: accepted beats are turned into expected
// uint8 beats by an arithmetic reference model and checked in order at the output.
`timescale 1ns/1ps
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif

module tb_concat_requant;
    localparam int RCN = 16;
    localparam int L   = `PICTURE_NUM * RCN;

    typedef logic [L*32-1:0] in_t;
    typedef logic [L*8-1:0]  out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    concat_requant_if #(.RE_CHANNEL_IN_NUM(RCN)) bus ();
    concat_requant #(.RE_CHANNEL_IN_NUM(RCN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_scale = 1;
    int   m_shift = 0;
    int   m_zp    = 0;
    bit   m_err   = 1'b0;
    bit   rnd_done;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // out = clamp(floor((x*scale + 2^(sh-1)) / 2^sh) + zp, 0, 255)
    function automatic logic [7:0] ref_lane(int x, int s, int sh, int zp);
        longint            pl;
        logic signed [127:0] p, d, num, q, y;
        pl = longint'(x) * longint'(s);
        p  = pl;
        if (sh == 0) q = p;
        else begin
            d   = 128'sd1 <<< sh;
            num = p + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0)) q = q - 1;
        end
        y = q + zp;
        if (y < 0) return 8'd0;
        if (y > 255) return 8'd255;
        return y[7:0];
    endfunction

    function automatic out_t ref_beat(in_t d);
        out_t o;
        for (int l = 0; l < L; l++)
            o[l*8 +: 8] = ref_lane(int'($signed(d[l*32 +: 32])), m_scale, m_shift, m_zp);
        return o;
    endfunction

    function automatic in_t fill(int v);
        in_t d;
        for (int l = 0; l < L; l++) d[l*32 +: 32] = v;
        return d;
    endfunction

    // Input-side observer: parameter loads and accepted beats feed the model.
    always begin
        @(negedge clk);
        if (!rst) begin
            if (bus.param_load) begin
                if (exp_q.size() == 0) begin
                    m_scale = int'($signed(bus.scale_in));
                    m_shift = int'(bus.shift_in);
                    m_zp    = int'(bus.zp_out_in);
                end else m_err = 1'b1;
            end
            if (bus.data_in_valid && bus.data_in_ready) exp_q.push_back(ref_beat(bus.data_in));
        end
    end

    // Output monitor: pops on every transfer, checks hold during stalls.
    out_t held;
    bit   holding = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (rst) holding = 1'b0;
        else begin
            if (holding) begin
                check("stall_valid_hold", 64'(bus.data_out_valid), 64'd1);
                checks++;
                if (bus.data_out !== held) begin
                    errors++;
                    $display("FAIL stall_data_hold: got %h expected %h", bus.data_out, held);
                end
            end
            holding = 1'b0;
            if (bus.data_out_valid) begin
                if (bus.data_out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected none", bus.data_out);
                    end else begin
                        out_t e;
                        e = exp_q.pop_front();
                        if (bus.data_out !== e) begin
                            errors++;
                            $display("FAIL beat: got %h expected %h", bus.data_out, e);
                        end
                    end
                end else begin
                    holding = 1'b1;
                    held    = bus.data_out;
                end
            end
        end
    end

    // Status monitor: busy follows beats in flight, param_err follows the model.
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            check("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
            check("param_err", 64'(bus.param_err), 64'(m_err));
        end
    end

    task automatic send(in_t d);
        int n;
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.data_in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no data_in_ready expected within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
    endtask

    task automatic load(int s, int sh, int zp);
        bus.param_load = 1'b1;
        bus.scale_in   = s;
        bus.shift_in   = 6'(sh);
        bus.zp_out_in  = 8'(zp);
        @(posedge clk);
        #1;
        bus.param_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_scale = 1;
        m_shift = 0;
        m_zp    = 0;
        m_err   = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t d;
        bus.param_load     = 1'b0;
        bus.scale_in       = '0;
        bus.shift_in       = '0;
        bus.zp_out_in      = '0;
        bus.data_in        = '0;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.data_out_valid), 64'd0);
        check("rst_out_zero", 64'(|bus.data_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_param_err", 64'(bus.param_err), 64'd0);
        check("rst_in_ready", 64'(bus.data_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Identity path with latency: handshake cycle c, output valid in cycle c+3.
        send(fill(100));
        check("lat_c1", 64'(bus.data_out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_c2", 64'(bus.data_out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_c3", 64'(bus.data_out_valid), 64'd1);
        send(fill(300));
        send(fill(-5));
        wait_idle();

        // Q31 half scale with zero point: 200->110, 3->12, -3->9.
        load(32'h40000000, 31, 10);
        send(fill(200));
        send(fill(3));
        send(fill(-3));
        wait_idle();

        // Backpressure mid-stream.
        load(1, 0, 0);
        fork
            begin
                for (int v = 1; v <= 5; v++) send(fill(v));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.data_out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.data_out_valid) check("stall_in_ready", 64'(bus.data_in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                bus.data_out_ready = 1'b1;
            end
        join
        wait_idle();

        // Load coinciding with the first beat: load wins, beat follows with scale=2.
        bus.param_load    = 1'b1;
        bus.scale_in      = 32'd2;
        bus.shift_in      = 6'd0;
        bus.zp_out_in     = 8'd0;
        bus.data_in       = fill(7);
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        check("load_blocks_in", 64'(bus.data_in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.param_load = 1'b0;
        send(fill(7));
        wait_idle();

        // Load attempted while busy is ignored and flagged.
        load(1, 0, 0);
        send(fill(50));
        load(5, 0, 0);
        check("perr_set", 64'(bus.param_err), 64'd1);
        send(fill(3));
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("perr_sticky", 64'(bus.param_err), 64'd1);
        do_reset();
        check("perr_cleared", 64'(bus.param_err), 64'd0);

        // Lane mapping: lane l carries l.
        for (int l = 0; l < L; l++) d[l*32 +: 32] = l;
        send(d);
        wait_idle();

        // Reset with two beats in flight: nothing may emerge afterwards.
        send(fill(11));
        send(fill(12));
        do_reset();
        check("rst_flight_valid", 64'(bus.data_out_valid), 64'd0);
        check("rst_flight_busy", 64'(bus.busy), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        // Extreme product and maximum shift: (2^62 + 2^62) >> 63 = 1.
        load(int'(32'h80000000), 63, 0);
        for (int l = 0; l < L; l++) d[l*32 +: 32] = (l % 2 == 0) ? 32'h80000000 : $urandom;
        send(d);
        load(int'(32'h80000000), 62, 3);
        wait_idle();
        load(int'(32'h80000000), 62, 3);
        send(d);
        wait_idle();

        // Randomized traffic with random backpressure under two parameter sets.
        for (int k = 0; k < 2; k++) begin
            load(int'($urandom), int'($urandom_range(26, 40)), int'($urandom_range(0, 255)));
            rnd_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 30; i++) begin
                        in_t r;
                        for (int l = 0; l < L; l++) r[l*32 +: 32] = $urandom;
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #0;
                        send(r);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        bus.data_out_ready = ($urandom_range(0, 3) != 0);
                        @(posedge clk);
                        #1;
                    end
                    bus.data_out_ready = 1'b1;
                end
            join
            wait_idle();
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
